// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Holds the FSM state encoding and the default width/depth constants.
package imem_fetch_ctrl_pkg;

  localparam int unsigned DefN     = 32;
  localparam int unsigned DefDepth = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, the external ROM and decode.
//   rom_addr/rom_instr         : combinational ROM read port
//   instr_out/pc_out/valid/rdy : buffered instruction handshake toward decode
//   redir_valid/redir_pc       : branch/jump redirect request
// master = fetch sequencer, slave = ROM + decode side.
interface imem_fetch_ctrl_if #(
  parameter int unsigned N = 32
);
  logic [N-1:0] rom_addr;
  logic [N-1:0] rom_instr;
  logic [N-1:0] instr_out;
  logic [N-1:0] pc_out;
  logic         instr_valid;
  logic         instr_ready;
  logic         redir_valid;
  logic [N-1:0] redir_pc;

  modport master (
    output rom_addr, instr_out, pc_out, instr_valid,
    input  rom_instr, instr_ready, redir_valid, redir_pc
  );

  modport slave (
    input  rom_addr, instr_out, pc_out, instr_valid,
    output rom_instr, instr_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl_buf.sv
// One-entry output buffer holding the fetched instruction and its word index.
//   load  : capture din/pin and mark valid
//   clear : drop the entry (wins over load)
//   instr_out/pc_out/valid : buffered entry
module imem_fetch_ctrl_buf #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [N-1:0] din,
  input  logic [N-1:0] pin,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] pc_out,
  output logic         valid
);

  logic [N-1:0] instr_q, pc_q;
  logic         valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= din;
      pc_q    <= pin;
      valid_q <= 1'b1;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid     = valid_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the word-addressed instruction ROM.
// Owns the PC, drives the ROM address, buffers the returned word toward decode,
// applies redirects, flags out-of-range targets and counts accepted words.
//   clk, rst_n  : clock, async active-low reset
//   start       : begin fetch at word 0 (IDLE/DONE only)
//   bus         : ROM port, decode handshake and redirect (master side)
//   busy, done  : state is RUN/DRAIN, state is DONE
//   err         : sticky out-of-range redirect flag, cleared by start
//   fetch_cnt   : accepted-instruction count, cleared by start
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned N     = DefN,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  imem_fetch_ctrl_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [N-1:0]        fetch_cnt
);

  localparam logic [N-1:0] LastIdx = N'(DEPTH - 1);

  fetch_state_e state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;
  logic         accept, redir, load, buf_clr;

  assign accept = bus.instr_valid & bus.instr_ready;
  assign redir  = bus.redir_valid & ((state_q == StRun) | (state_q == StDrain));
  // A load in RUN is needed whenever the buffer is empty or being drained.
  assign load   = (state_q == StRun) & (~bus.instr_valid | accept) & ~redir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    buf_clr = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept) cnt_d = cnt_q + N'(1);
        if (load) begin
          pc_d = pc_q + N'(1);
          if (pc_q == LastIdx) state_d = StDrain;
        end
      end
      StDrain: begin
        if (accept) begin
          cnt_d   = cnt_q + N'(1);
          buf_clr = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides everything, including counting a same-cycle accept.
    if (redir) begin
      buf_clr = 1'b1;
      cnt_d   = cnt_q;
      if (bus.redir_pc <= LastIdx) begin
        pc_d    = bus.redir_pc;
        state_d = StRun;
      end else begin
        err_d   = 1'b1;
        state_d = StDone;
      end
    end
  end

  imem_fetch_ctrl_buf #(
    .N (N)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .clear     (buf_clr),
    .din       (bus.rom_instr),
    .pin       (pc_q),
    .instr_out (bus.instr_out),
    .pc_out    (bus.pc_out),
    .valid     (bus.instr_valid)
  );

  assign bus.rom_addr = pc_q;
  assign busy         = (state_q == StRun) | (state_q == StDrain);
  assign done         = (state_q == StDone);
  assign err          = err_q;
  assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl with a six-word behavioural ROM.
// Expected word indices are queued as stimulus is planned and popped on each
// counted accept seen by the monitor.
module tb_imem_fetch_ctrl;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy, done, err;
  logic [N-1:0] fetch_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];

  imem_fetch_ctrl_if #(.N(N)) bus();

  imem_fetch_ctrl #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rom_word(input logic [N-1:0] a);
    return (32'h1000_0000 + a * 32'h0101_0101) ^ 32'h0000_005A;
  endfunction

  assign bus.rom_instr = rom_word(bus.rom_addr);

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(N'(i));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      step();
    end
    check("done_timeout", {31'd0, done}, 1);
  endtask

  // Scoreboard: each counted accept consumes one expected word index.
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready && !bus.redir_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accept", bus.pc_out, '1);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        check("acc_pc", bus.pc_out, e);
        check("acc_instr", bus.instr_out, rom_word(e));
      end
    end
  end

  initial begin
    bus.instr_ready = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = '0;

    // Reset values
    #12;
    check("rst_valid", {31'd0, bus.instr_valid}, 0);
    check("rst_pc_out", bus.pc_out, 0);
    check("rst_instr", bus.instr_out, 0);
    check("rst_addr", bus.rom_addr, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_cnt", fetch_cnt, 0);
    #1 rst_n = 1'b1;
    step();

    // Straight-line run at full throughput
    push_range(0, 5);
    bus.instr_ready = 1'b1;
    pulse_start();
    wait_done();
    check("s_cnt", fetch_cnt, 6);
    check("s_err", {31'd0, err}, 0);
    check("s_valid", {31'd0, bus.instr_valid}, 0);
    check("s_q_empty", exp_q.size(), 0);

    // Start latency and backpressure
    bus.instr_ready = 1'b0;
    pulse_start();
    check("bp_busy", {31'd0, busy}, 1);
    check("bp_lat_valid", {31'd0, bus.instr_valid}, 0);
    step();
    check("bp_first_valid", {31'd0, bus.instr_valid}, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_pc", bus.pc_out, 0);
      check("bp_hold_instr", bus.instr_out, rom_word(0));
      check("bp_hold_addr", bus.rom_addr, 1);
    end
    push_range(0, 5);
    bus.instr_ready = 1'b1;
    step();
    check("bp_next_pc", bus.pc_out, 1);
    wait_done();
    check("bp_cnt", fetch_cnt, 6);

    // In-range redirect discards the buffered word
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(4);
    exp_q.push_back(5);
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.instr_valid && bus.pc_out == 2) break;
    end
    check("rd_saw_pc2", bus.pc_out, 2);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 4;
    step();
    bus.redir_valid = 1'b0;
    check("rd_flush", {31'd0, bus.instr_valid}, 0);
    check("rd_addr", bus.rom_addr, 4);
    step();
    check("rd_target", bus.pc_out, 4);
    wait_done();
    check("rd_cnt", fetch_cnt, 4);
    check("rd_q_empty", exp_q.size(), 0);

    // Out-of-range redirect, then ignored redirect in DONE, then restart
    bus.instr_ready = 1'b0;
    pulse_start();
    step();
    bus.redir_valid = 1'b1;
    bus.redir_pc    = DEPTH;
    step();
    bus.redir_valid = 1'b0;
    check("oor_err", {31'd0, err}, 1);
    check("oor_done", {31'd0, done}, 1);
    check("oor_valid", {31'd0, bus.instr_valid}, 0);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 2;
    step();
    bus.redir_valid = 1'b0;
    check("done_redir_state", {31'd0, done}, 1);
    check("done_redir_addr", bus.rom_addr, 1);
    check("done_redir_cnt", fetch_cnt, 0);
    push_range(0, 5);
    bus.instr_ready = 1'b1;
    pulse_start();
    check("restart_err", {31'd0, err}, 0);
    check("restart_cnt", fetch_cnt, 0);
    wait_done();
    check("restart_fin_cnt", fetch_cnt, 6);

    // Ignored start during RUN
    bus.instr_ready = 1'b0;
    pulse_start();
    step();
    pulse_start();
    check("ign_start_pc", bus.pc_out, 0);
    check("ign_start_addr", bus.rom_addr, 1);
    check("ign_start_busy", {31'd0, busy}, 1);

    // Async reset mid-RUN, between edges
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, bus.instr_valid}, 0);
    check("ar_addr", bus.rom_addr, 0);
    check("ar_busy", {31'd0, busy}, 0);
    start           = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 3;
    step();
    step();
    check("ar_hold_busy", {31'd0, busy}, 0);
    check("ar_hold_addr", bus.rom_addr, 0);
    start           = 1'b0;
    bus.redir_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    bus.redir_valid = 1'b1;
    step();
    bus.redir_valid = 1'b0;
    check("idle_redir_busy", {31'd0, busy}, 0);
    check("idle_redir_addr", bus.rom_addr, 0);
    check("idle_redir_cnt", fetch_cnt, 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the word-addressed instruction ROM. It owns the program counter and drives the ROM word address. The ROM returns an instruction combinationally, and this block registers it into a one-entry output buffer with a valid/ready handshake toward decode. It also applies branch/jump redirects, detects end-of-program and out-of-range targets, and counts delivered instructions.

## Interface
Parameters:
- N, 32: instruction and PC width.
- DEPTH, 32: ROM depth in words. Legal word indices are 0..DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins fetch at word 0. Honoured only in IDLE or DONE.
- rom_addr  out  N  word index to the ROM, equal to pc.
- rom_instr  in  N  combinational ROM data for rom_addr.
- instr_out  out  N  buffered instruction.
- pc_out  out  N  word index of instr_out.
- instr_valid  out  1  instr_out/pc_out hold a valid instruction.
- instr_ready  in  1  decode accepts the instruction this cycle.
- redir_valid  in  1  redirect request.
- redir_pc  in  N  redirect target, word index.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- err  out  1  sticky flag: a redirect targeted an index >= DEPTH. Cleared by start.
- fetch_cnt  out  N  count of accepted instructions (valid & ready). Cleared by start.

## Operation
- Reset values: pc=0, instr_out=0, pc_out=0, instr_valid=0, err=0, fetch_cnt=0, state=IDLE. rom_addr follows pc, so it resets to 0.
- Definitions: accept = instr_valid & instr_ready. load = state RUN and (!instr_valid or accept).
- IDLE: outputs quiet. On start: pc<=0, fetch_cnt<=0, err<=0, go to RUN.
- RUN, normal load:
  - instr_out<=rom_instr, pc_out<=pc, instr_valid<=1, pc<=pc+1.
  - If the loaded pc == DEPTH-1, go to DRAIN.
- RUN, accept without a load: cannot occur. Any accept in RUN causes a load.
- DRAIN: no ROM reads matter. On accept: instr_valid<=0, go to DONE.
- DONE: done=1. start restarts exactly as from IDLE.
- Redirect (redir_valid in RUN or DRAIN) has highest priority:
  - It discards the buffered entry: instr_valid<=0, and fetch_cnt does not count it even if ready=1.
  - If redir_pc < DEPTH: pc<=redir_pc, state<=RUN.
  - Otherwise: err<=1, instr_valid<=0, state<=DONE.
  - redir_valid in IDLE or DONE is ignored.
- start in RUN or DRAIN is ignored.
- fetch_cnt increments by 1 on each accept that is not overridden by a redirect. It wraps modulo 2^N.
- pc arithmetic is unsigned N-bit. pc never exceeds DEPTH-1 while a read is issued.

## Timing
- start to first instr_valid: 2 cycles. Cycle 1 latches start to RUN; the load edge is cycle 2.
- Sustained throughput: 1 instruction per cycle while instr_ready=1. There are no bubbles between consecutive words.
- Backpressure: while instr_valid=1 and instr_ready=0, instr_out, pc_out and pc are held stable.
- Redirect: the target instruction is valid 2 edges after the redir_valid edge. The edge with redir_valid sets pc; the next edge loads.
- Asynchronous reset mid-operation returns all outputs to reset values immediately. Deassertion is synchronized externally.

## Structure
- Shared package (e.g. fetch_pkg) holds the state encoding (IDLE, RUN, DRAIN, DONE, 2 bits) and the default N/DEPTH constants.
- One sub-module is natural: fetch_buf, the one-entry valid/ready register holding instr_out/pc_out.
- The ROM remains external and is instantiated alongside, connected through rom_addr/rom_instr.

## Test plan
- Straight-line: start, instr_ready=1, ROM words 0..5 loaded, DEPTH=6 → six consecutive accepts with pc_out 0..5, then done=1, fetch_cnt=6, err=0.
- Backpressure: instr_ready=0 for 3 cycles after the first valid → instr_out and pc_out=0 held. After ready rises, pc_out 1 appears on the next edge with no skipped words.
- Redirect: in RUN with pc_out=2 valid and ready=1, assert redir_valid with redir_pc=4 → word 2 not counted, next valid pc_out=4.
- Out-of-range redirect: redir_pc=DEPTH → err=1, done=1, instr_valid=0. A following start clears err and fetch_cnt and restarts at pc_out 0.
- Async reset: drop rst_n mid-RUN between clock edges → instr_valid=0, pc=0, state IDLE immediately. start and redir_valid are ignored while in reset.
- Ignored inputs: start during RUN and redir_valid in IDLE/DONE → no state, pc or counter change.
